// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - register map, CTRL bit positions and channel duty pair type
package led_pwm_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_DUTY_LED = 3'd3;
  localparam logic [2:0] OFF_DUTY_R   = 3'd4;
  localparam logic [2:0] OFF_DUTY_G   = 3'd5;
  localparam logic [2:0] OFF_DUTY_B   = 3'd6;
  localparam logic [2:0] OFF_WRAPS    = 3'd7;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  typedef struct packed {
    logic [7:0] shadow;
    logic [7:0] active;
  } pwm_chan_t;

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one shadowed duty pair and its registered compare/polarity pin
module pwm_channel
  import led_pwm_pkg::*;
#(
  parameter logic ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       load,
  input  logic       en,
  input  logic       inv,
  input  logic [7:0] cnt,
  output logic [7:0] duty,
  output logic       pin
);

  pwm_chan_t chan;

  // load samples the pre-write shadow, so a write on a boundary waits a full period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chan <= '0;
      pin  <= ACTIVE_LOW;
    end else begin
      if (wr)
        chan.shadow <= wdata;
      if (load)
        chan.active <= chan.shadow;
      pin <= ((en && (cnt < chan.active)) ^ inv) ^ ACTIVE_LOW;
    end
  end

  assign duty = chan.shadow;

endmodule

// File: rtl/led_pwm_mmio.sv
// rtl/led_pwm_mmio.sv - memory-mapped LED/RGB PWM: decode, prescaler, period counter, read mux
module led_pwm_mmio
  import led_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic        ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  logic        hit;
  logic [2:0]  off;
  logic        wr_hit;
  logic        rd_hit;
  logic        en;
  logic        inv;
  logic [15:0] prescale;
  logic [15:0] pre_cnt;
  logic [15:0] wraps;
  logic [7:0]  period_sh;
  logic [7:0]  period_act;
  logic [7:0]  pwm_cnt;
  logic        tick;
  logic        wrap;
  logic        load;
  logic [7:0]  duties [4];
  logic [3:0]  pins;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign off    = addr[4:2];
  assign wr_hit = we && hit;
  assign rd_hit = re && hit;

  assign tick = en && (pre_cnt == prescale);
  // >= rather than == so a PERIOD reduced below pwm_cnt still wraps
  assign wrap = tick && (pwm_cnt >= period_act);
  assign load = !en || wrap;

  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en        <= 1'b0;
      inv       <= 1'b0;
      prescale  <= '0;
      period_sh <= '0;
    end else if (wr_hit) begin
      case (off)
        OFF_CTRL: begin
          en  <= wdata[CTRL_EN];
          inv <= wdata[CTRL_INV];
        end
        OFF_PRESCALE: prescale  <= wdata[15:0];
        OFF_PERIOD:   period_sh <= wdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      period_act <= '0;
      wraps      <= '0;
    end else begin
      if (!en) begin
        pre_cnt <= '0;
        pwm_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 16'd1;
      end
      if (wr_hit && (off == OFF_PRESCALE))
        pre_cnt <= '0;
      if (load)
        period_act <= period_sh;
      if (wr_hit && (off == OFF_WRAPS))
        wraps <= '0;
      else if (wrap)
        wraps <= wraps + 16'd1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_hit && (off == (OFF_DUTY_LED + 3'(i)))),
      .wdata (wdata[7:0]),
      .load  (load),
      .en    (en),
      .inv   (inv),
      .cnt   (pwm_cnt),
      .duty  (duties[i]),
      .pin   (pins[i])
    );
  end

  assign led   = pins[0];
  assign red   = pins[1];
  assign green = pins[2];
  assign blue  = pins[3];

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:     rd_mux = {30'd0, inv, en};
      OFF_PRESCALE: rd_mux = {16'd0, prescale};
      OFF_PERIOD:   rd_mux = {24'd0, period_sh};
      OFF_DUTY_LED: rd_mux = {24'd0, duties[0]};
      OFF_DUTY_R:   rd_mux = {24'd0, duties[1]};
      OFF_DUTY_G:   rd_mux = {24'd0, duties[2]};
      OFF_DUTY_B:   rd_mux = {24'd0, duties[3]};
      OFF_WRAPS:    rd_mux = {16'd0, wraps};
      default:      rd_mux = '0;
    endcase
  end

  // a miss leaves rdata untouched; only rvalid drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_hit;
      if (rd_hit)
        rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_led_pwm_mmio.sv
// tb/tb_led_pwm_mmio.sv - directed and randomized checks of led_pwm_mmio against a reference model
module tb_led_pwm_mmio;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        led, red, green, blue;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_mmio #(.BASE_ADDR(BASE), .ACTIVE_LOW(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .rdata  (rdata),
    .rvalid (rvalid),
    .led    (led),
    .red    (red),
    .green  (green),
    .blue   (blue)
  );

  // reference state, named after the register map
  logic        m_en, m_inv;
  logic [15:0] m_prescale, m_pre, m_wraps;
  logic [7:0]  m_per_sh, m_per_act, m_cnt;
  logic [7:0]  m_dsh [4];
  logic [7:0]  m_dact [4];
  logic [3:0]  m_pins;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  function automatic logic [31:0] m_reg(input logic [2:0] o);
    case (o)
      3'd0: return {30'd0, m_inv, m_en};
      3'd1: return {16'd0, m_prescale};
      3'd2: return {24'd0, m_per_sh};
      3'd7: return {16'd0, m_wraps};
      default: return {24'd0, m_dsh[o - 3'd3]};
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic       hit, tick, boundary;
    logic [2:0] o;
    if (!reset) begin
      m_en = 0; m_inv = 0; m_prescale = 0; m_pre = 0; m_wraps = 0;
      m_per_sh = 0; m_per_act = 0; m_cnt = 0; m_rdata = 0; m_rvalid = 0;
      m_pins = 4'hF;
      for (int i = 0; i < 4; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
    end else begin
      hit = (addr[31:5] == BASE[31:5]);
      o   = addr[4:2];
      m_rvalid = re && hit;
      if (m_rvalid) m_rdata = m_reg(o);
      for (int i = 0; i < 4; i++)
        m_pins[i] = ~((m_en && (m_cnt < m_dact[i])) ^ m_inv);
      tick     = m_en && (m_pre == m_prescale);
      boundary = tick && (m_cnt >= m_per_act);
      if (!m_en || boundary) begin
        m_per_act = m_per_sh;
        for (int i = 0; i < 4; i++) m_dact[i] = m_dsh[i];
      end
      if (!m_en) begin
        m_pre = 0; m_cnt = 0;
      end else if (tick) begin
        m_pre = 0;
        if (boundary) begin m_cnt = 0; m_wraps = m_wraps + 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        m_pre = m_pre + 1;
      end
      if (we && hit) begin
        case (o)
          3'd0: begin m_en = wdata[0]; m_inv = wdata[1]; end
          3'd1: begin m_prescale = wdata[15:0]; m_pre = 0; end
          3'd2: m_per_sh = wdata[7:0];
          3'd7: m_wraps = 0;
          default: m_dsh[o - 3'd3] = wdata[7:0];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("led", 32'(led), 32'(m_pins[0]));
    chk("red", 32'(red), 32'(m_pins[1]));
    chk("green", 32'(green), 32'(m_pins[2]));
    chk("blue", 32'(blue), 32'(m_pins[3]));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    addr = BASE + 32'(o) * 4; wdata = d; we = 1;
    step();
    we = 0;
  endtask

  task automatic rd(input logic [2:0] o);
    addr = BASE + 32'(o) * 4; re = 1;
    step();
    re = 0;
  endtask

  task automatic count_red(input int n, output int ons);
    ons = 0;
    repeat (n) begin step(); ons += (red == 1'b0) ? 1 : 0; end
  endtask

  initial begin
    int ons;
    logic found;
    logic [2:0] o;

    reset = 1;
    #1 reset = 0;
    #2;
    chk("reset_pins", 32'({led, red, green, blue}), 32'hF);
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_rdata", rdata, 0);
    check_all();
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      chk("rd_reset_val", rdata, 0);
      chk("rd_reset_valid", 32'(rvalid), 1);
    end

    wr(3'd1, 0); wr(3'd2, 9); wr(3'd4, 3); wr(3'd0, 1);
    count_red(10, ons);
    chk("red_on_3of10", 32'(ons), 3);
    repeat (40) step();
    rd(3'd7);
    chk("wraps_after_50", rdata, 5);

    wr(3'd4, 7);
    repeat (12) step();
    count_red(10, ons);
    chk("red_on_7of10", 32'(ons), 7);

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt == 8'd9) found = 1; else step();
    end
    chk("found_boundary", 32'(found), 1);
    wr(3'd4, 5);
    count_red(10, ons);
    chk("boundary_write_delayed", 32'(ons), 7);
    count_red(10, ons);
    chk("boundary_write_applied", 32'(ons), 5);

    wr(3'd5, 0); wr(3'd6, 255);
    repeat (12) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("green_off", 32'(green), 1);
      chk("blue_on", 32'(blue), 0);
    end
    wr(3'd0, 3);
    step();
    chk("green_inv", 32'(green), 0);
    chk("blue_inv", 32'(blue), 1);

    wr(3'd0, 0); wr(3'd1, 3); wr(3'd2, 1); wr(3'd0, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_en && m_pre == m_prescale && m_cnt >= m_per_act) found = 1; else step();
    end
    chk("found_wrap_edge", 32'(found), 1);
    wr(3'd7, 32'hFFFF);
    rd(3'd7);
    chk("wraps_clear_wins", rdata, 0);
    repeat (15) step();
    rd(3'd7);
    chk("wraps_every_8", rdata, 2);

    repeat (3) step();
    @(posedge clk);
    #3 reset = 0;
    #1;
    chk("async_reset_pins", 32'({led, red, green, blue}), 32'hF);
    check_all();
    @(negedge clk);
    reset = 1;
    rd(3'd4);
    chk("post_reset_duty_r", rdata, 0);
    chk("post_reset_rvalid", 32'(rvalid), 1);
    addr = 32'h0000_2010; re = 1;
    step();
    re = 0;
    chk("miss_no_rvalid", 32'(rvalid), 0);

    wr(3'd2, 32'($urandom_range(0, 12)));
    for (int i = 3; i < 7; i++) wr(3'(i), 32'($urandom_range(0, 15)));
    wr(3'd0, 1);
    repeat (600) begin
      o     = 3'($urandom_range(0, 7));
      addr  = (($urandom % 8) == 0) ? 32'h0000_3000 + 32'(o) * 4 : BASE + 32'(o) * 4;
      wdata = $urandom;
      if (o == 3'd1) wdata[15:0] = 16'($urandom_range(0, 3));
      if (o == 3'd2) wdata[7:0]  = 8'($urandom_range(0, 12));
      if (o == 3'd0) wdata[0]    = ($urandom % 4) != 0;
      we = ($urandom % 5) == 0;
      re = ($urandom % 3) == 0;
      step();
      we = 0; re = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
